joy_serial: RTL and testbench

- Reads two DB9 joysticks through the board's external 74HC165-style parallel-in/serial-out shift chain.
- Drives the chain's clock and load lines, shifts in 16 bits per scan, and filters glitches with a two-frame agreement check.
- Presents active-high 8-bit joystick words to the zx core's joy1/joy2 inputs, alongside or in place of the SPI-delivered joystick words.
- Sits directly upstream of zx.

---
 rtl/joy_serial.sv | 177 +++++++++++++++++
 tb/tb_joy_serial.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/joy_serial.sv
// Scans two DB9 joysticks through an external 74HC165-style shift chain and
// publishes debounced, active-high joystick words for the zx core.
//
// state | meaning
// IDLE  | wait PERIOD ticks between scans
// LOAD  | joyLd low for one tick to latch the chain's parallel inputs
// SHIFT | 16 bits, each bit is phase A (sample, raise joyCk) then phase B (lower joyCk)
// EVAL  | one clock: SOCD cleanup, two-frame agreement filter, output update
module joy_serial #(
    parameter int CKDIV  = 28,
    parameter int PERIOD = 2000,
    parameter bit SOCD   = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    output logic       joyCk,
    output logic       joyLd,
    input  logic       joyD,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       strb
);

    localparam int DIV_W = (CKDIV > 1) ? $clog2(CKDIV) : 1;
    localparam int PER_W = (PERIOD > 0) ? $clog2(PERIOD + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CKDIV - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_EVAL
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [3:0]        bit_q, bit_d;
    logic              phase_q, phase_d;
    logic [15:0]       sr_q, sr_d;
    logic [15:0]       prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic              ck_q, ck_d;
    logic              ld_q, ld_d;
    logic [7:0]        joy1_q, joy1_d;
    logic [7:0]        joy2_q, joy2_d;
    logic              strb_q, strb_d;

    logic              tick;
    logic [7:0]        map1, map2;
    logic [15:0]       mapped;

    // Opposing directions pressed together cancel: up/down are [3:2], left/right [1:0].
    function automatic logic [7:0] socd_fix(input logic [7:0] j);
        logic [7:0] r;
        r = j;
        if (SOCD) begin
            if (j[3] && j[2]) r[3:2] = 2'b00;
            if (j[1] && j[0]) r[1:0] = 2'b00;
        end
        return r;
    endfunction

    assign tick   = (div_q == DIV_LAST);
    assign map1   = socd_fix(~sr_q[15:8]);
    assign map2   = socd_fix(~sr_q[7:0]);
    assign mapped = {map1, map2};

    always_comb begin
        state_d      = state_q;
        div_d        = tick ? '0 : div_q + 1'b1;
        per_d        = per_q;
        bit_d        = bit_q;
        phase_d      = phase_q;
        sr_d         = sr_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        ck_d         = ck_q;
        ld_d         = ld_q;
        joy1_d       = joy1_q;
        joy2_d       = joy2_q;
        strb_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    if (per_q == PER_LAST) begin
                        per_d   = '0;
                        ld_d    = 1'b0;
                        state_d = ST_LOAD;
                    end else begin
                        per_d = per_q + 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (tick) begin
                    ld_d    = 1'b1;
                    bit_d   = 4'd0;
                    phase_d = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        // The chain presents QH before each rising joyCk, so sample first.
                        sr_d    = {sr_q[14:0], joyD};
                        ck_d    = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        ck_d    = 1'b0;
                        phase_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            state_d = ST_EVAL;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
            end
            ST_EVAL: begin
                if (prev_valid_q && (mapped == prev_q) && (mapped != {joy1_q, joy2_q})) begin
                    joy1_d = map1;
                    joy2_d = map2;
                    strb_d = 1'b1;
                end
                prev_d       = mapped;
                prev_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            per_q        <= '0;
            bit_q        <= 4'd0;
            phase_q      <= 1'b0;
            sr_q         <= 16'h0000;
            prev_q       <= 16'hFFFF;
            prev_valid_q <= 1'b0;
            ck_q         <= 1'b0;
            ld_q         <= 1'b1;
            joy1_q       <= 8'h00;
            joy2_q       <= 8'h00;
            strb_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            per_q        <= per_d;
            bit_q        <= bit_d;
            phase_q      <= phase_d;
            sr_q         <= sr_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            ck_q         <= ck_d;
            ld_q         <= ld_d;
            joy1_q       <= joy1_d;
            joy2_q       <= joy2_d;
            strb_q       <= strb_d;
        end
    end

    assign joyCk = ck_q;
    assign joyLd = ld_q;
    assign joy1  = joy1_q;
    assign joy2  = joy2_q;
    assign strb  = strb_q;

endmodule

// File: tb/tb_joy_serial.sv
// Directed bench for joy_serial with a behavioural 74HC165 chain model;
// a second instance with SOCD=0 shares the chain to contrast opposing-direction handling.
module tb_joy_serial;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        joyD;
    logic        joyCk, joyLd, strb;
    logic [7:0]  joy1, joy2;
    logic        ck_n, ld_n, strb_n;
    logic [7:0]  joy1_n, joy2_n;

    logic [15:0] frame_r = 16'hFFFF;
    logic [15:0] chain   = 16'hFFFF;

    int checks = 0;
    int errors = 0;
    int strb_cnt = 0;
    int strb_cnt_n = 0;
    int ck_rises = 0;
    int overlap = 0;
    int pair_diff = 0;

    joy_serial #(.CKDIV(4), .PERIOD(8), .SOCD(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .joyCk (joyCk),
        .joyLd (joyLd),
        .joyD  (joyD),
        .joy1  (joy1),
        .joy2  (joy2),
        .strb  (strb)
    );

    joy_serial #(.CKDIV(4), .PERIOD(8), .SOCD(1'b0)) dut_nosocd (
        .clock (clock),
        .reset (reset),
        .joyCk (ck_n),
        .joyLd (ld_n),
        .joyD  (joyD),
        .joy1  (joy1_n),
        .joy2  (joy2_n),
        .strb  (strb_n)
    );

    always #5 clock = ~clock;

    // Chain model: parallel load on joyLd falling, shift toward QH on joyCk rising.
    assign joyD = chain[15];
    always @(negedge joyLd) chain = frame_r;
    always @(posedge joyCk) begin
        chain = {chain[14:0], 1'b1};
        ck_rises++;
    end

    always @(negedge clock) begin
        if (strb === 1'b1) strb_cnt++;
        if (strb_n === 1'b1) strb_cnt_n++;
        if (joyLd === 1'b0 && joyCk === 1'b1) overlap++;
        if (ck_n !== joyCk || ld_n !== joyLd) pair_diff++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ld(output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (joyLd && n < 400);
        chk("ld_wait", 32'(n < 400), 32'd1);
    endtask

    task automatic do_scan(input logic [15:0] f);
        int n;
        int r0;
        frame_r = f;
        wait_ld(n);
        r0 = ck_rises;
        repeat (140) @(posedge clock);
        #1;
        chk("ck_pulses", 32'(ck_rises - r0), 32'd16);
    endtask

    initial begin
        int n, m, lo, hi, bad, ld_ck;
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, lo, hi, bad, ld_ck;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ck",   32'(joyCk), 32'd0);
        chk("rst_ld",   32'(joyLd), 32'd1);
        chk("rst_joy1", 32'(joy1),  32'd0);
        chk("rst_joy2", 32'(joy2),  32'd0);
        chk("rst_strb", 32'(strb),  32'd0);

        // Waveform timing on an all-released chain.
        frame_r = 16'hFFFF;
        @(negedge clock) reset = 1'b0;
        wait_ld(n);
        chk("first_ld_delay", 32'(n), 32'd32);
        m = 0;
        ld_ck = 0;
        while (!joyLd && m < 50) begin
            @(posedge clock);
            #1;
            m++;
            if (joyCk) ld_ck++;
        end
        chk("ld_low_clocks", 32'(m), 32'd4);
        chk("ck_during_ld", 32'(ld_ck), 32'd0);
        bad = 0;
        for (int p = 0; p < 16; p++) begin
            lo = 0;
            while (!joyCk && lo < 50) begin
                @(posedge clock);
                #1;
                lo++;
            end
            hi = 0;
            while (joyCk && hi < 50) begin
                @(posedge clock);
                #1;
                hi++;
            end
            if (lo != 4 || hi != 4) bad++;
        end
        chk("ck_shape", 32'(bad), 32'd0);
        repeat (10) @(posedge clock);
        #1;
        chk("ffff_joy1", 32'(joy1), 32'd0);
        chk("ffff_joy2", 32'(joy2), 32'd0);
        chk("ffff_strb", 32'(strb_cnt), 32'd0);

        // Stable input needs two agreeing scans.
        do_scan(16'h7EFE);
        chk("stable1_joy1", 32'(joy1), 32'h00);
        chk("stable1_strb", 32'(strb_cnt), 32'd0);
        do_scan(16'h7EFE);
        chk("stable2_joy1", 32'(joy1), 32'h81);
        chk("stable2_joy2", 32'(joy2), 32'h01);
        chk("stable2_strb", 32'(strb_cnt), 32'd1);
        do_scan(16'h7EFE);
        chk("stable3_strb", 32'(strb_cnt), 32'd1);
        chk("stable3_joy1", 32'(joy1), 32'h81);

        do_scan(16'hFFFF);
        chk("back1_joy1", 32'(joy1), 32'h81);
        do_scan(16'hFFFF);
        chk("back2_joy1", 32'(joy1), 32'h00);
        chk("back2_joy2", 32'(joy2), 32'h00);
        chk("back2_strb", 32'(strb_cnt), 32'd2);

        // One-scan glitch.
        do_scan(16'hEFFF);
        chk("glitch_joy1", 32'(joy1), 32'h00);
        do_scan(16'hFFFF);
        do_scan(16'hFFFF);
        chk("glitch_after_joy1", 32'(joy1), 32'h00);
        chk("glitch_strb", 32'(strb_cnt), 32'd2);

        // Press fire1 then release.
        do_scan(16'hEFFF);
        do_scan(16'hEFFF);
        chk("fire_joy1", 32'(joy1), 32'h10);
        chk("fire_strb", 32'(strb_cnt), 32'd3);
        do_scan(16'hFFFF);
        chk("rel1_joy1", 32'(joy1), 32'h10);
        do_scan(16'hFFFF);
        chk("rel2_joy1", 32'(joy1), 32'h00);
        chk("rel2_strb", 32'(strb_cnt), 32'd4);

        // Opposing directions.
        do_scan(16'hF3FF);
        do_scan(16'hF3FF);
        chk("socd_ud_joy1", 32'(joy1), 32'h00);
        chk("nosocd_ud_joy1", 32'(joy1_n), 32'h0C);
        chk("socd_ud_strb", 32'(strb_cnt), 32'd4);
        chk("nosocd_ud_strb", 32'(strb_cnt_n), 32'd5);
        do_scan(16'hFFFC);
        do_scan(16'hFFFC);
        chk("socd_lr_joy2", 32'(joy2), 32'h00);
        chk("nosocd_lr_joy2", 32'(joy2_n), 32'h03);
        chk("nosocd_lr_joy1", 32'(joy1_n), 32'h00);
        chk("nosocd_lr_strb", 32'(strb_cnt_n), 32'd6);

        // Reset in the middle of a scan.
        do_scan(16'h7EFE);
        do_scan(16'h7EFE);
        chk("pre_rst_joy1", 32'(joy1), 32'h81);
        frame_r = 16'h7EFE;
        wait_ld(n);
        repeat (26) @(posedge clock);
        #1;
        chk("pre_rst_ck_high", 32'(joyCk), 32'd1);
        @(negedge clock) reset = 1'b1;
        #1;
        chk("mid_rst_ck",   32'(joyCk), 32'd0);
        chk("mid_rst_ld",   32'(joyLd), 32'd1);
        chk("mid_rst_joy1", 32'(joy1),  32'd0);
        chk("mid_rst_joy2", 32'(joy2),  32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        wait_ld(n);
        chk("rst_ld_delay", 32'(n), 32'd32);
        repeat (140) @(posedge clock);
        #1;
        chk("post_rst1_joy1", 32'(joy1), 32'h00);
        do_scan(16'h7EFE);
        chk("post_rst2_joy1", 32'(joy1), 32'h81);
        chk("post_rst2_joy2", 32'(joy2), 32'h01);

        chk("ld_ck_overlap", 32'(overlap), 32'd0);
        chk("instances_agree", 32'(pair_diff), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
